// File: rtl/mapa_arbiter.sv
// mapa_arbiter: shares the map RAM between the renderer and three writers.
// Define MAPA_ARB_CONFLICT_EN to build same-cell write collision detect.
module mapa_arbiter #(
  parameter int MAPA_WIDTH   = 40,
  parameter int MAPA_HEIGHT  = 30,
  parameter int ADDR_W       = 11,
  parameter int MAX_RD_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_active,
  input  logic              rd_req,
  input  logic [9:0]        rd_x,
  input  logic [9:0]        rd_y,
  output logic              rd_grant,
  output logic              rd_valid,
  output logic [3:0]        rd_data,
  input  logic [2:0]        wr_req,
  input  logic [29:0]       wr_x,
  input  logic [29:0]       wr_y,
  input  logic [11:0]       wr_block,
  output logic [2:0]        wr_grant,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [3:0]        ram_wdata,
  input  logic [3:0]        ram_rdata,
  output logic              conflict,
  output logic [2:0]        conflict_mask
);
  localparam int BW = $clog2(MAX_RD_BURST + 1);
  localparam logic [9:0] W10 = 10'(MAPA_WIDTH);
  localparam logic [9:0] H10 = 10'(MAPA_HEIGHT);
  localparam logic [BW-1:0] BMAX = BW'(MAX_RD_BURST);

  logic [1:0]    rr_ptr;
  logic [BW-1:0] burst_cnt;
  logic          rd_oor_q;

  logic          rd_el;
  logic [2:0]    wr_el;
  logic          any_w;
  logic          do_rd;
  logic          do_wr;
  logic [1:0]    widx;
  logic [2:0]    pick;
  logic [9:0]    wx;
  logic [9:0]    wy;
  logic [3:0]    wblk;
  logic [9:0]    sx;
  logic [9:0]    sy;
  logic [19:0]   lin;
  logic          oor;

  // a live grant masks its own requester for one edge
  assign rd_el = rd_req & ~rd_grant;
  assign wr_el = wr_req & ~wr_grant;
  assign any_w = |wr_el;

  always_comb begin
    widx = 2'd0;
    case (rr_ptr)
      2'd1:    widx = wr_el[1] ? 2'd1 : (wr_el[2] ? 2'd2 : 2'd0);
      2'd2:    widx = wr_el[2] ? 2'd2 : (wr_el[0] ? 2'd0 : 2'd1);
      default: widx = wr_el[0] ? 2'd0 : (wr_el[1] ? 2'd1 : 2'd2);
    endcase
    pick = 3'b001 << widx;
  end

  always_comb begin
    wx   = wr_x[9:0];
    wy   = wr_y[9:0];
    wblk = wr_block[3:0];
    unique case (1'b1)
      pick[1]: begin
        wx   = wr_x[19:10];
        wy   = wr_y[19:10];
        wblk = wr_block[7:4];
      end
      pick[2]: begin
        wx   = wr_x[29:20];
        wy   = wr_y[29:20];
        wblk = wr_block[11:8];
      end
      default: ;
    endcase
  end

  always_comb begin
    do_rd = 1'b0;
    do_wr = 1'b0;
    if (vga_active) begin
      do_wr = any_w;
      do_rd = ~any_w & rd_el;
    end else if (burst_cnt == BMAX && any_w) begin
      do_wr = 1'b1;
    end else if (rd_req) begin
      // a waiting renderer keeps blanking for itself
      do_rd = rd_el;
    end else begin
      do_wr = any_w;
    end
  end

  assign sx  = do_wr ? wx : rd_x;
  assign sy  = do_wr ? wy : rd_y;
  assign lin = 20'(sy) * 20'(MAPA_WIDTH) + 20'(sx);
  assign oor = (sx >= W10) || (sy >= H10);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_grant  <= 1'b0;
      wr_grant  <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rd_valid  <= 1'b0;
      rd_oor_q  <= 1'b0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      rd_grant <= do_rd;
      wr_grant <= do_wr ? pick : 3'b000;
      ram_we   <= do_wr & ~oor;
      rd_valid <= rd_grant;
      if (do_rd | do_wr) ram_addr <= lin[ADDR_W-1:0];
      if (do_wr) ram_wdata <= wblk;
      if (do_rd) rd_oor_q <= oor;
      if (do_wr) rr_ptr <= (widx == 2'd2) ? 2'd0 : widx + 2'd1;
      if (do_wr || wr_req == 3'b000)
        burst_cnt <= '0;
      else if (do_rd && any_w && burst_cnt != BMAX)
        burst_cnt <= burst_cnt + BW'(1);
    end
  end

  // off-map reads return the wall code
  assign rd_data = !rd_valid ? 4'd0 : (rd_oor_q ? 4'b0010 : ram_rdata);

`ifdef MAPA_ARB_CONFLICT_EN
  logic       e01;
  logic       e02;
  logic       e12;
  logic [2:0] cmask;

  assign e01 = wr_el[0] & wr_el[1] &
               (wr_x[9:0] == wr_x[19:10]) & (wr_y[9:0] == wr_y[19:10]);
  assign e02 = wr_el[0] & wr_el[2] &
               (wr_x[9:0] == wr_x[29:20]) & (wr_y[9:0] == wr_y[29:20]);
  assign e12 = wr_el[1] & wr_el[2] &
               (wr_x[19:10] == wr_x[29:20]) & (wr_y[19:10] == wr_y[29:20]);
  assign cmask = {e02 | e12, e01 | e12, e01 | e02};

  always_ff @(posedge clk) begin
    if (reset) begin
      conflict      <= 1'b0;
      conflict_mask <= '0;
    end else begin
      conflict      <= do_wr & (|cmask);
      conflict_mask <= do_wr ? cmask : 3'b000;
    end
  end
`else
  assign conflict      = 1'b0;
  assign conflict_mask = 3'b000;
`endif
endmodule

// File: tb/tb_mapa_arbiter.sv
// tb_mapa_arbiter: directed + random checks of mapa_arbiter
// against a behavioural model of the arbitration rules.
module tb_mapa_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        vga_active;
  logic        rd_req;
  logic [9:0]  rd_x, rd_y;
  logic        rd_grant, rd_valid;
  logic [3:0]  rd_data;
  logic [2:0]  wr_req;
  logic [29:0] wr_x, wr_y;
  logic [11:0] wr_block;
  logic [2:0]  wr_grant;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [3:0]  ram_wdata;
  logic [3:0]  ram_rdata;
  logic        conflict;
  logic [2:0]  conflict_mask;

  int n_chk = 0;
  int n_err = 0;

  mapa_arbiter dut (
    .clk(clk), .reset(reset), .vga_active(vga_active),
    .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y),
    .rd_grant(rd_grant), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_block(wr_block),
    .wr_grant(wr_grant), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .conflict(conflict), .conflict_mask(conflict_mask)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] init_val(int a);
    return 4'(a * 7 + 3);
  endfunction

  // synchronous RAM
  logic [3:0] mem [2048];
  bit         seen [2048];
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr]  <= ram_wdata;
      seen[ram_addr] <= 1'b1;
    end
    ram_rdata <= seen[ram_addr] ? mem[ram_addr] : init_val(int'(ram_addr));
  end

  // reference model state
  logic [3:0] shadow [2048];
  bit         m_rdg, m_we, m_rd_oor, m_rdv, m_conf;
  bit [2:0]   m_wrg, m_mask;
  int         m_rr, m_burst, m_addr;
  bit [3:0]   m_wdata, m_rdata;

  task automatic model_step();
    bit       rd_el, oor, isw;
    bit [2:0] we, mask;
    int       c, win, x, y, nv;
    bit [3:0] nd;
    if (m_we) shadow[m_addr] = m_wdata;
    nv = m_rdg;
    nd = m_rdg ? (m_rd_oor ? 4'b0010 : shadow[m_addr]) : 4'd0;
    if (reset) begin
      m_rdg = 0; m_wrg = 0; m_we = 0; m_rd_oor = 0; m_rdv = 0;
      m_conf = 0; m_mask = 0; m_rr = 0; m_burst = 0; m_addr = 0;
      m_wdata = 0; m_rdata = 0;
      return;
    end
    rd_el = rd_req && !m_rdg;
    for (int i = 0; i < 3; i++) we[i] = wr_req[i] && !m_wrg[i];
    c = -1;
    for (int k = 0; k < 3; k++)
      if (c < 0 && we[(m_rr + k) % 3]) c = (m_rr + k) % 3;
    if (vga_active) win = (c >= 0) ? c : (rd_el ? 3 : -1);
    else if (m_burst == 16 && c >= 0) win = c;
    else if (rd_req) win = rd_el ? 3 : -1;
    else win = c;
    isw = (win >= 0 && win < 3);
    if (win == 3) begin
      x = rd_x; y = rd_y;
    end else if (isw) begin
      x = wr_x[10*win +: 10]; y = wr_y[10*win +: 10];
    end else begin
      x = 0; y = 0;
    end
    oor = (x >= 40) || (y >= 30);
    mask = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if (i != j && we[i] && we[j] &&
            wr_x[10*i +: 10] == wr_x[10*j +: 10] &&
            wr_y[10*i +: 10] == wr_y[10*j +: 10]) mask[i] = 1;
    if (isw || wr_req == 0) m_burst = 0;
    else if (win == 3 && c >= 0 && m_burst < 16) m_burst++;
`ifdef MAPA_ARB_CONFLICT_EN
    m_conf = isw && mask != 0;
    m_mask = isw ? mask : 3'b000;
`else
    m_conf = 0;
    m_mask = 0;
`endif
    m_rdg = (win == 3);
    m_wrg = isw ? 3'(1 << win) : 3'b000;
    m_we  = isw && !oor;
    if (win >= 0) m_addr = (y * 40 + x) % 2048;
    if (isw) begin
      m_wdata = wr_block[4*win +: 4];
      m_rr = (win + 1) % 3;
    end
    if (win == 3) m_rd_oor = oor;
    m_rdv = nv[0];
    m_rdata = nd;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("rd_grant", rd_grant, m_rdg);
    chk("wr_grant", wr_grant, m_wrg);
    chk("ram_we", ram_we, m_we);
    chk("rd_valid", rd_valid, m_rdv);
    chk("rd_data", rd_data, m_rdata);
    chk("conflict", conflict, m_conf);
    chk("conflict_mask", conflict_mask, m_mask);
    if (m_rdg || m_wrg != 0) chk("ram_addr", ram_addr, m_addr);
    if (m_we) chk("ram_wdata", ram_wdata, m_wdata);
  endtask

  task automatic do_reset();
    reset = 1; rd_req = 0; wr_req = 0;
    cyc();
    cyc();
    reset = 0;
  endtask

  function automatic logic [9:0] rx();
    return 10'($urandom_range(0, 44));
  endfunction

  function automatic logic [9:0] ry();
    return 10'($urandom_range(0, 33));
  endfunction

  initial begin
    int nrd;
    logic [2:0] exp4 [4];
    exp4 = '{3'b001, 3'b010, 3'b100, 3'b001};
    for (int i = 0; i < 2048; i++) shadow[i] = init_val(i);
    reset = 1; vga_active = 0;
    rd_req = 1; rd_x = 1; rd_y = 1;
    wr_req = 3'b111; wr_x = {10'd3, 10'd2, 10'd1};
    wr_y = {10'd4, 10'd4, 10'd4}; wr_block = 12'h321;

    // reset with every request high
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t1_rst_out", {rd_grant, wr_grant, ram_we, rd_valid, rd_data,
                         conflict, conflict_mask}, 0);
      chk("t1_rst_addr", ram_addr, 0);
    end
    reset = 0;
    cyc();
    chk("t1_first_grant", rd_grant, 1);

    // read ahead of write in blanking
    do_reset();
    vga_active = 0;
    rd_req = 1; rd_x = 5; rd_y = 2;
    wr_req = 3'b001; wr_x[9:0] = 1; wr_y[9:0] = 1; wr_block[3:0] = 9;
    cyc();
    chk("t2_rd_first", rd_grant, 1);
    chk("t2_addr", ram_addr, 85);
    chk("t2_no_wr", wr_grant, 0);
    rd_req = 0;
    cyc();
    chk("t2_valid", rd_valid, 1);
    chk("t2_wr_after", wr_grant, 3'b001);
    wr_req = 0;
    cyc();

    // burst limit
    do_reset();
    rd_req = 1; rd_x = 10; rd_y = 10;
    wr_req = 3'b010; wr_x[19:10] = 8; wr_y[19:10] = 8; wr_block[7:4] = 4;
    nrd = 0;
    for (int k = 0; k < 80; k++) begin
      cyc();
      if (rd_grant) nrd++;
      if (wr_grant != 0) break;
    end
    chk("t3_reads", nrd, 16);
    chk("t3_forced_wr", wr_grant, 3'b010);
    wr_req = 0;
    cyc();
    chk("t3_resume", rd_grant, 1);
    rd_req = 0;
    cyc();

    // round robin in active video
    do_reset();
    vga_active = 1; rd_req = 1; wr_req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t4_order", wr_grant, exp4[k]);
      chk("t4_rd_held", rd_grant, 0);
    end
    wr_req = 0;
    cyc();
    chk("t4_rd_served", rd_grant, 1);
    rd_req = 0;
    cyc();

    // off-map accesses
    do_reset();
    vga_active = 0;
    rd_req = 1; rd_x = 40; rd_y = 0;
    cyc();
    rd_req = 0;
    cyc();
    chk("t5_wall", rd_data, 4'b0010);
    wr_req = 3'b100; wr_x[29:20] = 3; wr_y[29:20] = 30; wr_block[11:8] = 5;
    cyc();
    chk("t5_wr_grant", wr_grant, 3'b100);
    chk("t5_dropped", ram_we, 0);
    wr_req = 0;
    cyc();

    // same-cell writers
    do_reset();
    vga_active = 1;
    wr_req = 3'b011;
    wr_x[19:0] = {10'd7, 10'd7}; wr_y[19:0] = {10'd7, 10'd7};
    wr_block[7:0] = 8'h6A;
    cyc();
    chk("t6_grant", wr_grant, 3'b001);
`ifdef MAPA_ARB_CONFLICT_EN
    chk("t6_conflict", conflict, 1);
    chk("t6_mask", conflict_mask, 3'b011);
`else
    chk("t6_conflict", conflict, 0);
`endif
    wr_req = 3'b010;
    cyc();
    chk("t6_second", wr_grant, 3'b010);
    wr_req = 0;
    cyc();

    // random traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 199) == 0) vga_active = ~vga_active;
      reset = ($urandom_range(0, 599) == 0);
      if (m_rdg) begin
        rd_req = $urandom_range(0, 1) == 1;
        rd_x = rx(); rd_y = ry();
      end else if (!rd_req && $urandom_range(0, 2) == 0) begin
        rd_req = 1; rd_x = rx(); rd_y = ry();
      end
      for (int i = 0; i < 3; i++) begin
        if (m_wrg[i] || (!wr_req[i] && $urandom_range(0, 3) == 0)) begin
          wr_req[i] = m_wrg[i] ? ($urandom_range(0, 1) == 1) : 1'b1;
          if ($urandom_range(0, 3) == 0) begin
            wr_x[10*i +: 10] = 6; wr_y[10*i +: 10] = 6;
          end else begin
            wr_x[10*i +: 10] = rx(); wr_y[10*i +: 10] = ry();
          end
          wr_block[4*i +: 4] = 4'($urandom);
        end
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
